// File: rtl/ram_burst_ctrl_pkg.sv
// Shared types and constants for the RAM burst controller and its output buffer.
package ram_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam int BUF_DEPTH = 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/ram_skid_buf.sv
// Small FIFO that absorbs RAM read data; head entry is presented combinationally.
module ram_skid_buf
    import ram_burst_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a single-port synchronous RAM: one command at a
// time, streamed write beats in, read beats out through a 2-entry buffer.
module ram_burst_ctrl
    import ram_burst_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d;

    logic [CNT_W-1:0]      buf_count;
    logic                  pop, last, wr_acc, issue;

    assign cmd_ready = rst_n && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign wr_ready  = (state_q == S_WRITE);
    assign wr_acc    = wr_valid && wr_ready;
    assign rd_valid  = (buf_count != '0);
    assign pop       = rd_valid && rd_ready;
    assign last      = (rem_q == '0);

    // Count the in-flight read as occupied so the buffer can never overflow.
    assign issue = (state_q == S_READ) &&
                   (int'(buf_count) + int'(pend_q) < BUF_DEPTH + int'(pop));

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_cs   = cs_q;
    assign ram_we   = we_q;
    assign ram_oe   = oe_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        pend_d     = issue;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        oe_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_acc) begin
                    ram_addr_d = addr_q;
                    ram_din_d  = wr_data;
                    cs_d       = 1'b1;
                    we_d       = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (last) state_d = S_IDLE;
                end
            end
            S_READ: begin
                // oe stays high across READ/DRAIN so the RAM output remains driven.
                cs_d = 1'b1;
                oe_d = 1'b1;
                if (issue) begin
                    ram_addr_d = addr_q;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                    if (last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pend_q) begin
                    cs_d = 1'b1;
                    oe_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            pend_q     <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            pend_q     <= pend_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
        end
    end

    // A read issued last cycle has its data on ram_dout now.
    ram_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pend_q),
        .din_i   (ram_dout),
        .pop_i   (pop),
        .head_o  (rd_data),
        .count_o (buf_count)
    );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl against a behavioural single-port RAM and a flat
// memory-array reference model of burst semantics.
module tb_ram_burst_ctrl;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic [7:0] ram_addr, ram_din, ram_dout;
    logic       ram_cs, ram_we, ram_oe, busy;

    ram_burst_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_cs(ram_cs),
        .ram_we(ram_we), .ram_oe(ram_oe), .ram_dout(ram_dout), .busy(busy)
    );

    // RAM: writes on the edge; read data follows the registered address pins.
    logic [7:0] ram_mem [256];
    always @(posedge clk) if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_din;
    assign ram_dout = (ram_cs && ram_oe && !ram_we) ? ram_mem[ram_addr] : 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       wr;
        logic [7:0] addr, len, d0;
        int         mode, gap, exp_cnt;
        logic [7:0] exp_a0, exp_alast, exp_dfirst, exp_dlast;
        int         exp_idle, exp_lat;
    } vec_t;

    int         total, bad;
    logic [7:0] ref_mem [256];
    logic [7:0] wq[$], got_d[$], wl_a[$], wl_d[$];
    int         idle_cyc, lat_cyc;
    logic       timed_out;

    function automatic vec_t mk(logic wr, logic [7:0] addr, logic [7:0] len, logic [7:0] d0,
                                int mode, int gap, int cnt, logic [7:0] a0, logic [7:0] al,
                                logic [7:0] df, logic [7:0] dl, int idle, int lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.d0 = d0; v.mode = mode; v.gap = gap;
        v.exp_cnt = cnt; v.exp_a0 = a0; v.exp_alast = al; v.exp_dfirst = df;
        v.exp_dlast = dl; v.exp_idle = idle; v.exp_lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy_pat(int mode, int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc - 1) % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Drives one burst cycle by cycle; inputs change just after the rising
    // edge and handshakes are observed on the falling edge.
    task automatic run_burst(input logic wr, input logic [7:0] addr, input logic [7:0] len,
                             input int mode, input int gap);
        int n, beat, gapc, wait_c;
        n = int'(len) + 1; beat = 0; gapc = 0; wait_c = 0;
        got_d.delete(); wl_a.delete(); wl_d.delete();
        idle_cyc = -1; lat_cyc = -1; timed_out = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        while (!cmd_ready) begin
            wait_c++;
            if (wait_c > 100) begin
                timed_out = 1'b1;
                cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        timed_out = 1'b1;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            if (wr && beat < n && gapc == 0) begin
                wr_valid = 1'b1;
                wr_data  = wq[beat];
            end else begin
                wr_valid = 1'b0;
            end
            rd_ready = wr ? 1'b1 : rdy_pat(mode, cyc);
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                beat++;
                gapc = gap;
            end else if (gapc > 0) begin
                gapc--;
            end
            if (rd_valid && rd_ready) got_d.push_back(rd_data);
            if (ram_cs && ram_we) begin
                wl_a.push_back(ram_addr);
                wl_d.push_back(ram_din);
            end
            if (rd_valid && lat_cyc < 0) lat_cyc = cyc;
            if (!busy && idle_cyc < 0) idle_cyc = cyc;
            if ((wr ? wl_a.size() == n : got_d.size() == n) && !busy && !rd_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    // Runs a burst and checks every beat against the reference memory.
    task automatic do_burst(input string nm, input logic wr, input logic [7:0] addr,
                            input logic [7:0] len, input int mode, input int gap);
        int n, mism, distinct;
        bit seen [256];
        n = int'(len) + 1;
        run_burst(wr, addr, len, mode, gap);
        chk({nm, " timeout"}, 64'(timed_out), 64'd0);
        mism = 0;
        if (wr) begin
            chk({nm, " wcnt"}, 64'(wl_a.size()), 64'(n));
            for (int i = 0; i < n && i < wl_a.size(); i++)
                if (wl_a[i] !== 8'(int'(addr) + i) || wl_d[i] !== wq[i]) mism++;
            chk({nm, " wseq"}, 64'(mism), 64'd0);
            distinct = 0;
            for (int i = 0; i < 256; i++) seen[i] = 1'b0;
            foreach (wl_a[i]) if (!seen[wl_a[i]]) begin seen[wl_a[i]] = 1'b1; distinct++; end
            chk({nm, " distinct"}, 64'(distinct), 64'(n));
            for (int i = 0; i < n; i++) ref_mem[8'(int'(addr) + i)] = wq[i];
        end else begin
            chk({nm, " rcnt"}, 64'(got_d.size()), 64'(n));
            for (int i = 0; i < n && i < got_d.size(); i++)
                if (got_d[i] !== ref_mem[8'(int'(addr) + i)]) mism++;
            chk({nm, " rseq"}, 64'(mism), 64'd0);
        end
    endtask

    vec_t       tv[9];
    logic [7:0] first_v, last_v, fa, la;
    int         nb;

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        //            wr    addr   len    d0    md gp cnt  a0     alast  dfirst dlast  idle lat
        tv[0] = mk(1'b1, 8'h80, 8'hFF, 8'h00, 0, 0, 256, 8'h80, 8'h7F, 8'h00, 8'hFF, 257, -1);
        tv[1] = mk(1'b0, 8'h80, 8'hFF, 8'h00, 0, 0, 256, 8'h00, 8'h00, 8'h00, 8'hFF, 259, 3);
        tv[2] = mk(1'b1, 8'h10, 8'h03, 8'hA0, 0, 0, 4,   8'h10, 8'h13, 8'hA0, 8'hA3, 5,   -1);
        tv[3] = mk(1'b0, 8'h10, 8'h03, 8'h00, 0, 0, 4,   8'h00, 8'h00, 8'hA0, 8'hA3, 7,   3);
        tv[4] = mk(1'b0, 8'h10, 8'h03, 8'h00, 1, 0, 4,   8'h00, 8'h00, 8'hA0, 8'hA3, -1,  3);
        tv[5] = mk(1'b1, 8'hFE, 8'h03, 8'h01, 0, 0, 4,   8'hFE, 8'h01, 8'h01, 8'h04, 5,   -1);
        tv[6] = mk(1'b0, 8'hFE, 8'h03, 8'h00, 0, 0, 4,   8'h00, 8'h00, 8'h01, 8'h04, 7,   3);
        tv[7] = mk(1'b1, 8'h40, 8'h02, 8'h55, 0, 3, 3,   8'h40, 8'h42, 8'h55, 8'h57, 10,  -1);
        tv[8] = mk(1'b0, 8'h40, 8'h02, 8'h00, 2, 0, 3,   8'h00, 8'h00, 8'h55, 8'h57, -1,  3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ctl outs", 64'({cmd_ready, busy, rd_valid, wr_ready, ram_cs, ram_we, ram_oe}), 64'd0);
        chk("reset ram bus", 64'({ram_addr, ram_din}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("after reset", 64'({cmd_ready, busy, rd_valid, wr_ready}), 64'b1000);

        foreach (tv[k]) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            wq.delete();
            for (int i = 0; i <= int'(tv[k].len); i++) wq.push_back(8'(int'(tv[k].d0) + i));
            do_burst(nm, tv[k].wr, tv[k].addr, tv[k].len, tv[k].mode, tv[k].gap);
            if (tv[k].wr) begin
                fa = (wl_a.size() > 0) ? wl_a[0] : 8'hxx;
                la = (wl_a.size() > 0) ? wl_a[wl_a.size()-1] : 8'hxx;
                first_v = (wl_d.size() > 0) ? wl_d[0] : 8'hxx;
                last_v  = (wl_d.size() > 0) ? wl_d[wl_d.size()-1] : 8'hxx;
                chk({nm, " count"}, 64'(wl_a.size()), 64'(tv[k].exp_cnt));
                chk({nm, " first addr"}, 64'(fa), 64'(tv[k].exp_a0));
                chk({nm, " last addr"}, 64'(la), 64'(tv[k].exp_alast));
            end else begin
                first_v = (got_d.size() > 0) ? got_d[0] : 8'hxx;
                last_v  = (got_d.size() > 0) ? got_d[got_d.size()-1] : 8'hxx;
                chk({nm, " count"}, 64'(got_d.size()), 64'(tv[k].exp_cnt));
            end
            chk({nm, " first data"}, 64'(first_v), 64'(tv[k].exp_dfirst));
            chk({nm, " last data"}, 64'(last_v), 64'(tv[k].exp_dlast));
            if (tv[k].exp_idle >= 0) chk({nm, " idle cycle"}, 64'(idle_cyc), 64'(tv[k].exp_idle));
            if (tv[k].exp_lat >= 0) chk({nm, " first rd_valid"}, 64'(lat_cyc), 64'(tv[k].exp_lat));
        end

        // Reset in the middle of an 8-beat read, after two beats were taken.
        wq.delete();
        for (int i = 0; i < 8; i++) wq.push_back(8'(8'h30 + i));
        do_burst("pre-reset wr", 1'b1, 8'h20, 8'h07, 0, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20; cmd_len = 8'h07; rd_ready = 1'b1;
        @(negedge clk);
        chk("midrst cmd_ready", 64'(cmd_ready), 64'd1);
        nb = 0;
        for (int c = 0; c < 50 && nb < 2; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                chk($sformatf("midrst beat%0d", nb), 64'(rd_data), 64'(ref_mem[8'(8'h20 + nb)]));
                nb++;
            end
        end
        chk("midrst beats seen", 64'(nb), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst ctl outs", 64'({cmd_ready, busy, rd_valid, wr_ready, ram_cs, ram_we, ram_oe}), 64'd0);
        chk("midrst ram bus", 64'({ram_addr, ram_din}), 64'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst release", 64'({cmd_ready, busy, rd_valid}), 64'b100);
        do_burst("post-reset rd", 1'b0, 8'h20, 8'h07, 0, 0);

        // Random bursts against the reference memory.
        for (int r = 0; r < 24; r++) begin
            logic       rw;
            logic [7:0] ra, rl;
            rw = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rl = 8'($urandom_range(0, 12));
            wq.delete();
            for (int i = 0; i <= int'(rl); i++) wq.push_back(8'($urandom));
            do_burst($sformatf("rand%0d", r), rw, ra, rl, 2, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Burst access controller that sits directly upstream of the single-port synchronous RAM (RAM_sync / RAM_sync2) and drives its address, data_in, cs, we and oe pins.
- Accepts one burst command at a time (write or read, start address, length) over a valid/ready handshake.
- Streams write beats in and read beats out, each over its own valid/ready handshake.
- Hides the RAM's one-cycle registered-read latency and tri-state output behind a 2-entry output buffer, sustaining one beat per cycle.

Parameters:
- DATA_WIDTH, 8, RAM word width; must match the RAM.
- ADDR_WIDTH, 8, RAM address width; the RAM depth is 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_len  in  ADDR_WIDTH  beats minus 1 (0 means 1 beat; all-ones means 2^ADDR_WIDTH beats).
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted when high together with wr_valid.
- wr_data  in  DATA_WIDTH  write beat payload.
- rd_valid  out  1  read beat valid (the output buffer is non-empty).
- rd_ready  in  1  downstream accepts the read beat.
- rd_data  out  DATA_WIDTH  head of the output buffer.
- ram_addr  out  ADDR_WIDTH  to RAM address; registered.
- ram_din  out  DATA_WIDTH  to RAM data_in; registered.
- ram_cs, ram_we, ram_oe  out  1 each  to RAM cs/we/oe; registered.
- ram_dout  in  DATA_WIDTH  from RAM data_out.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0) clears everything:
  - state returns to IDLE.
  - All ram_* outputs, rd_valid, wr_ready and busy go to 0.
  - Buffer count and read-pending flag go to 0.
  - cmd_ready is 0 while rst_n=0 and 1 after release.
- Reset mid-burst abandons the burst with no completion; the output buffer contents are lost.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_valid & cmd_ready latches the address into an address counter and cmd_len into a remaining-beats counter.
  - Next state is WRITE if cmd_write=1, otherwise READ.
- WRITE:
  - wr_ready=1 combinationally.
  - Each accepted beat registers ram_addr=addr, ram_din=wr_data, ram_cs=1, ram_we=1, ram_oe=0. The RAM writes at the following edge, so write latency is 1 cycle after acceptance.
  - The address increments by 1 modulo 2^ADDR_WIDTH (wraps from all-ones to 0).
  - On the last beat the next state is IDLE.
  - Any cycle without an accepted beat registers ram_cs=0 and ram_we=0.
  - The final write pulse is driven during the first IDLE cycle; it cannot collide with a new command, whose first RAM op appears one cycle later at the earliest.
- READ:
  - ram_cs=1, ram_oe=1, ram_we=0 are held for the whole of READ and DRAIN, so the RAM tri-state output stays driven.
  - Issue condition: count + pend - pop < 2, where pop = rd_valid & rd_ready. When true, ram_addr=addr is registered, addr increments with wrap, and pend is set for the next cycle.
  - A beat issued in cycle t is captured from ram_dout at the end of cycle t+1 and pushed into the buffer.
  - After the last issue the next state is DRAIN.
  - Redundant RAM reads caused by holding oe while not issuing are harmless and expected.
- DRAIN:
  - Waits until the final issued beat is captured (pend=0).
  - Then deasserts ram_cs and ram_oe and returns to IDLE.
  - Beats still in the buffer keep draining to the consumer after IDLE; a new command may be accepted while they drain.
- Output buffer:
  - 2-entry FIFO; rd_data is the head entry.
  - Push and pop in the same cycle are allowed.
  - Never overflows, by construction of the issue rule.
  - With rd_ready held at 1, throughput is 1 beat/cycle and first-beat latency is 2 cycles after leaving IDLE.
- Write bursts make no ordering guarantee against unread buffer contents. The buffer only ever holds earlier read data.
- A 2^ADDR_WIDTH-beat burst touches every address exactly once.

Decomposition:
- Header ram_ctrl_defs.vh holds:
  - localparams for the state encodings S_IDLE, S_WRITE, S_READ, S_DRAIN.
  - the buffer depth constant (2).
- One sub-module, ram_skid_buf: 2-entry FIFO with push/pop, count and head output, parameterised by DATA_WIDTH.
- Bench couples ram_burst_ctrl to RAM_sync2 with matching parameters.

Test Plan:
- Write burst, addr=0x10, len=3, data 0xA0..0xA3, wr_valid always high -> 4 consecutive RAM write pulses at 0x10..0x13; cmd_ready returns 1 after the 4th acceptance.
- Read burst, addr=0x10, len=3, rd_ready=1 -> rd_valid from 2 cycles after the command, data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles; busy falls after DRAIN.
- Same read with rd_ready toggling 1,0,0,1,... -> no lost or duplicated beats; buffer count never exceeds 2; beat order preserved.
- Wrap: write addr=0xFE, len=3, data 1..4, then read back 0xFE, len=3 -> addresses 0xFE,0xFF,0x00,0x01; read returns 1,2,3,4.
- wr_valid gaps: write len=2 with wr_valid low for 3 cycles between beats -> ram_cs=0 during the gaps; exactly 3 writes occur.
- Asynchronous reset asserted mid-read (after 2 of 8 beats) -> all outputs 0 immediately; after release, state IDLE, cmd_ready=1, rd_valid=0, and a new read burst returns correct data.
